// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: result state
// encoding, flag bit positions and requester IDs.
package adder_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                     input logic c, input logic v);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/adder_gate.sv
// 32-bit combinational adder with N/Z/C/V status outputs.
// N is suppressed on signed overflow so it reflects the true sign only.
module adder_gate
    import adder_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              n,
    output logic              z,
    output logic              c,
    output logic              v
);

    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sum      = full_sum[DATA_W-1:0];
    assign c        = full_sum[DATA_W];
    assign v        = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign n        = sum[DATA_W-1] & ~v;
    assign z        = (sum == '0);

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder; round-robin arbitration feeds a single
// registered result slot with a valid/ready response handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_EMPTY | no result held, a grant may be issued
//   ST_FULL  | result held in rsp_*, new grant only if drained
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic [FLAG_W-1:0] rsp_flags
);

    state_t            state;
    logic              ptr;
    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              grant;
    logic              grant_id;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] add_sum;
    logic              add_n;
    logic              add_z;
    logic              add_c;
    logic              add_v;

    // Gating with rst keeps both readys low for the whole reset window.
    assign can_accept = ~rst & ((state == ST_EMPTY) | rsp_ready);
    assign grant0     = can_accept & req0_valid & (~req1_valid | (ptr == REQ_ID_0));
    assign grant1     = can_accept & req1_valid & (~req0_valid | (ptr == REQ_ID_1));
    assign grant      = grant0 | grant1;
    assign grant_id   = grant1 ? REQ_ID_1 : REQ_ID_0;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;

    adder_gate u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum),
        .n   (add_n),
        .z   (add_z),
        .c   (add_c),
        .v   (add_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            ptr       <= RR_INIT;
            rsp_id    <= REQ_ID_0;
            rsp_sum   <= '0;
            rsp_flags <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (grant) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (rsp_ready && !grant) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
            if (grant) begin
                rsp_id    <= grant_id;
                rsp_sum   <= add_sum;
                rsp_flags <= pack_flags(add_n, add_z, add_c, add_v);
                ptr       <= ~grant_id;
            end
        end
    end

    assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table, random
// traffic against an arithmetic reference model, backpressure and reset cases.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_sum;
    logic [3:0]  rsp_flags;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_valid;
    bit          m_id;
    bit          m_ptr;
    logic [31:0] m_sum;
    logic [3:0]  m_flags;
    bit          obs_r0, obs_r1;

    adder_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_flags  (rsp_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          v0;
        logic [31:0] a0, b0;
        bit          v1;
        logic [31:0] a1, b1;
        bit          rr;
        bit          e_rdy0, e_rdy1, e_valid, e_id;
        logic [31:0] e_sum;
        logic [3:0]  e_flags;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0;
        m_id    = 0;
        m_ptr   = 1'b0;
        m_sum   = '0;
        m_flags = '0;
    endfunction

    // Flags from plain signed/unsigned arithmetic on wide integers.
    function automatic void model_add(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] s, output logic [3:0] f);
        longint          sa;
        longint unsigned ua;
        bit              n, z, c, v;
        sa = longint'($signed(a)) + longint'($signed(b));
        ua = longint'(a) + longint'(b);
        s  = ua[31:0];
        c  = (ua >= 64'h1_0000_0000);
        v  = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        z  = (s == 0);
        n  = (sa < 0) && !v;
        f  = {n, z, c, v};
    endfunction

    // One clock: drive at posedge+1, check readys mid-cycle, check rsp after the edge.
    task automatic cycle(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                         input bit rr);
        bit          can, g;
        bit          win;
        logic [31:0] s;
        logic [3:0]  f;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        #2;
        can = !m_valid || rr;
        g   = can && (v0 || v1);
        if (v0 && v1) win = m_ptr;
        else          win = v1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        chk("req0_ready", 32'(req0_ready), 32'(g && win == 1'b0));
        chk("req1_ready", 32'(req1_ready), 32'(g && win == 1'b1));
        @(posedge clk);
        if (g) begin
            model_add(win ? a1 : a0, win ? b1 : b0, s, f);
            m_valid = 1;
            m_id    = win;
            m_sum   = s;
            m_flags = f;
            m_ptr   = !win;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        vecs[0] = '{1, 32'd5, 32'd7, 1, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 1, 0, 32'd12, 4'b0000};
        vecs[1] = '{1, 32'd9, 32'd9, 1, 32'hFFFF_FFFF, 32'd1, 1, 0, 1, 1, 1, 32'd0, 4'b0110};
        vecs[2] = '{1, 32'h7FFF_FFFF, 32'd1, 1, 32'd3, 32'd4, 1, 1, 0, 1, 0, 32'h8000_0000, 4'b0001};
        vecs[3] = '{1, 32'd1, 32'd1, 1, 32'h8000_0000, 32'h8000_0000, 1, 0, 1, 1, 1, 32'd0, 4'b0111};
        vecs[4] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd0, 1, 1, 0, 1, 0, 32'hFFFF_FFFE, 4'b1010};
        vecs[5] = '{0, 32'd0, 32'd0, 1, 32'd2, 32'd3, 1, 0, 1, 1, 1, 32'd5, 4'b0000};
        vecs[6] = '{0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1, 0, 0, 0, 1, 32'd5, 4'b0000};

        rst = 1'b1;
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1; req1_a = 32'd1; req1_b = 32'd1;
        rsp_ready  = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_sum", rsp_sum, 32'd0);
        chk("reset rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset req0_ready", 32'(req0_ready), 32'd0);
        chk("reset req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 0; req1_valid = 0;
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // directed table: contention, flag corners, single requesters, drain
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
            chk($sformatf("vec%0d ready0", i), 32'(obs_r0), 32'(vecs[i].e_rdy0));
            chk($sformatf("vec%0d ready1", i), 32'(obs_r1), 32'(vecs[i].e_rdy1));
            chk($sformatf("vec%0d valid", i), 32'(rsp_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d id", i), 32'(rsp_id), 32'(vecs[i].e_id));
            chk($sformatf("vec%0d sum", i), rsp_sum, vecs[i].e_sum);
            chk($sformatf("vec%0d flags", i), 32'(rsp_flags), 32'(vecs[i].e_flags));
        end

        // random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1) == 1, rnd_op(), rnd_op(),
                  $urandom_range(0, 1) == 1, rnd_op(), rnd_op(),
                  $urandom_range(0, 9) < 7);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // backpressure: earlier result held while req1 waits
        cycle(1, 32'd10, 32'd20, 0, 0, 0, 1);
        chk("bp first sum", rsp_sum, 32'd30);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 32'd2, 32'd3, 0);
            chk($sformatf("bp hold ready1 %0d", k), 32'(obs_r1), 32'd0);
            chk($sformatf("bp hold sum %0d", k), rsp_sum, 32'd30);
            chk($sformatf("bp hold id %0d", k), 32'(rsp_id), 32'd0);
            chk($sformatf("bp hold valid %0d", k), 32'(rsp_valid), 32'd1);
        end
        cycle(0, 0, 0, 1, 32'd2, 32'd3, 1);
        chk("bp release ready1", 32'(obs_r1), 32'd1);
        chk("bp release sum", rsp_sum, 32'd5);
        chk("bp release id", 32'(rsp_id), 32'd1);

        // reset while FULL with priority pointing at requester 1
        cycle(1, 32'd4, 32'd4, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("pre-reset valid", 32'(rsp_valid), 32'd1);
        #3;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        rst = 1'b1;
        #1;
        chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async reset sum", rsp_sum, 32'd0);
        chk("async reset req0_ready", 32'(req0_ready), 32'd0);
        chk("async reset req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        chk("reset held valid", 32'(rsp_valid), 32'd0);
        req0_valid = 0; req1_valid = 0;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cycle(1, 32'd6, 32'd6, 1, 32'd8, 32'd8, 1);
        chk("post-reset first grant ready0", 32'(obs_r0), 32'd1);
        chk("post-reset first sum", rsp_sum, 32'd12);
        chk("post-reset first id", 32'(rsp_id), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an add operation pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 addends (signed, two's complement).
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same widths and meaning as the requester 0 ports, for requester 1.
REQ-008 rsp_valid  output  1  result register holds an undelivered result.
REQ-009 rsp_ready  input  1  consumer takes the result this cycle.
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_sum  output  32  registered sum.
REQ-012 rsp_flags  output  4  registered flags {N,Z,C,V}.

Function
REQ-013 The block SHALL share one combinational 32-bit adder between the two requesters and SHALL register exactly one result at a time.
- Handshake: a transfer occurs when valid and ready are both high in the same cycle.
REQ-014 State machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- EMPTY->FULL on a grant.
- FULL->EMPTY on rsp_ready with no grant.
- FULL->FULL on rsp_ready with a grant in the same cycle.
- FULL holds otherwise.
REQ-015 Accept rule: can_accept = EMPTY or (FULL and rsp_ready); a grant is possible only when can_accept=1.
REQ-016 Arbitration: if only one requester is valid, that requester is granted; if both are valid, the priority holder is granted.
REQ-017 Priority pointer: after each grant, the pointer moves to the non-granted requester; it is unchanged when there is no grant.
REQ-018 Ready outputs: reqN_ready SHALL be combinational, high only for the granted requester, and at most one ready SHALL be high per cycle.
REQ-019 Latency: a result granted in cycle t SHALL appear on rsp_* in cycle t+1; throughput is one result per cycle while rsp_ready is held high.
REQ-020 On grant, the block SHALL register sum = (a+b) mod 2^32, and:
- C = carry out of bit 31;
- V = (a[31]==b[31]) and (sum[31]!=a[31]);
- N = sum[31] and not V;
- Z = (sum==0).
REQ-021 While FULL and rsp_ready=0, rsp_sum, rsp_flags and rsp_id SHALL hold stable, and both readys SHALL be 0.
REQ-022 Requester inputs MAY change freely while not granted; only values present in the grant cycle are used.
REQ-023 A requester that deasserts valid before its grant SHALL lose no state and SHALL NOT be granted.

Reset
REQ-024 While rst=1, the block SHALL set: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_flags=0, state=EMPTY, pointer=RR_INIT; the reset is asynchronous and takes effect without a clock edge.
REQ-025 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-026 A result pending when reset asserts SHALL be discarded, and the first grant after release SHALL follow RR_INIT priority.

Structure
REQ-027 A shared package SHALL hold:
- the state encoding constants (EMPTY, FULL);
- the flag bit positions (N=3, Z=2, C=1, V=0);
- the requester ID constants.
REQ-028 The adder SHALL be one sub-module instance, adder_gate (32-bit add with Z,V,C,N outputs); its output flags feed the result register directly.
REQ-029 The arbiter, pointer and result register SHALL live in adder_arbiter itself, in roughly 150-250 lines, with no other sub-modules.

Verification
REQ-030 Single requester:
- Stimulus: req0 a=5, b=7, rsp_ready=1.
- Response: next cycle rsp_valid=1, id=0, sum=12, flags=0000.
REQ-031 Contention:
- Stimulus: both requesters valid for 4 cycles, RR_INIT=0, rsp_ready=1.
- Response: grants 0,1,0,1; each rsp_id matches its grant.
REQ-032 Flag corners:
- 0x7FFFFFFF+1 -> sum 0x80000000, V=1, N=0, C=0.
- 0xFFFFFFFF+1 -> sum 0, Z=1, C=1, V=0.
- 0x80000000+0x80000000 -> sum 0, Z=1, C=1, V=1.
REQ-033 Backpressure:
- Stimulus: rsp_ready=0 for 3 cycles with req1 valid (2+3).
- Response: rsp holds the earlier result, req1_ready=0 throughout; when rsp_ready rises, req1 is granted that cycle and sum=5 appears next cycle.
REQ-034 Reset mid-operation:
- Stimulus: assert rst while FULL, between clock edges.
- Response: rsp_valid falls immediately; after release with both requesters valid, requester RR_INIT is granted first.
